bit_serial_exec: RTL and testbench
==================================

# bit_serial_exec

Bit-serial execution unit of the CPU: accepts one decoded instruction (4-bit opcode plus 12-bit instruction word) from the instruction-entry front end and executes it LSB-first through a 1-bit ALU over WIDTH cycles. It holds the accumulator and C/Z flags. The accumulator drives the LED result bus. Start is a one-cycle pulse, issued by the front end once both instruction bytes are loaded.

## Interface
- WIDTH, 8, datapath/accumulator width; immediate is instr[WIDTH-1:0]; legal range 2..12.

- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle execute request; sampled only in IDLE
- opcode  input  4  operation select, sampled with start
- instr  input  12  instruction word; instr[WIDTH-1:0] = immediate, rest reserved/ignored
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; acc/flags final in this cycle
- acc_out  output  WIDTH  architectural accumulator (LED bus)
- acc_dbg  output  WIDTH  live accumulator shift-register contents (gate-level debug)
- c_flag  output  1  carry flag
- z_flag  output  1  zero flag

## Operation
- Opcodes:
  - 0 NOP
  - 1 LDI acc=imm
  - 2 ADD acc+=imm
  - 3 SUB acc-=imm
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 ADC acc+=imm+C
  - 8 SHL acc<<=1
  - 9 SHR acc>>=1 (logical)
  - 10–15 behave as NOP.
- FSM:
  - IDLE→LOAD on start.
  - LOAD→SHIFT.
  - SHIFT holds for WIDTH cycles (bit counter 0..WIDTH-1), then →WRITE.
  - WRITE→IDLE.
- LOAD:
  - Latch opcode; copy acc into A shift reg and imm into B shift reg.
  - Carry-in is 1 for SUB, C for ADC, else 0.
  - SUB uses ~B.
- SHIFT: each cycle the 1-bit ALU consumes A[0], B[0] and the carry reg, shifts the result bit into the result reg MSB, and shifts A and B right.
  - SHL: result bit = carry reg (previous A bit, initially 0); carry reg ← A[0].
  - SHR: result bit = A[1]; the last bit is 0.
- WRITE: acc ← result (NOP: unchanged).
- Flags:
  - ADD/ADC/SUB: C = final carry-out (SUB: C=1 means no borrow, acc ≥ imm unsigned).
  - SHL: C = old acc[WIDTH-1]. SHR: C = old acc[0].
  - LDI and logic ops: C unchanged.
  - Z = (new acc == 0) for all opcodes except NOP-class, which leave Z unchanged.
- Arithmetic wraps modulo 2^WIDTH.
- start while busy is ignored: no queueing, no effect on the operation in flight.
- Reset, including mid-operation: state IDLE, acc=0, C=0, Z=0, busy=0, done=0, shift regs and counter 0. An interrupted operation produces no done and leaves no partial acc update.

## Timing
- Reset values: busy 0, done 0, acc_out 0, acc_dbg 0, c_flag 0, z_flag 0.
- start high in IDLE at edge E0 → busy=1 from E0.
- LOAD occupies E0..E1; SHIFT edges are E2..E(WIDTH+1); WRITE is edge E(WIDTH+2).
- After E(WIDTH+2): busy=0, done=1 for exactly one cycle, and acc_out/flags are updated in that same cycle.
- Latency is start edge to done edge = WIDTH+2 edges (10 for WIDTH=8). Throughput is one instruction per WIDTH+3 cycles.
- start may be asserted in the done cycle; it is accepted (state is IDLE).
- acc_out is stable between WRITE edges. acc_dbg changes during SHIFT.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package cpu_pkg:
  - opcode localparams (OP_NOP…OP_SHR)
  - FSM state encoding (ST_IDLE, ST_LOAD, ST_SHIFT, ST_WRITE)
  - default WIDTH
- Sub-module serial_alu_bit: combinational 1-bit ALU.
  - Inputs: a, b, a_next, cin, op.
  - Outputs: r, cout.
- The top of this block holds the FSM, counter, shift regs and flags.

## Test plan
- Reset, then LDI imm 0x5A → done exactly 10 cycles after start; acc 0x5A, Z=0, C=0; busy high for the 10 intervening cycles.
- LDI 0xF0 then ADD 0x20 → acc 0x10, C=1, Z=0. Then SUB 0x10 → acc 0x00, Z=1, C=1. Then SUB 0x01 → acc 0xFF, C=0, Z=0.
- LDI 0xFF, ADD 0x01 → acc 0x00, C=1, Z=1. Then ADC 0x10 → acc 0x11, C=0. AND 0x0F → 0x01; OR 0x80 → 0x81; XOR 0xFF → 0x7E, C unchanged.
- LDI 0x81, SHL → acc 0x02, C=1. Then LDI 0x81, SHR → acc 0x40, C=1. Opcode 0xC → acc and flags unchanged, done still pulses.
- start pulses at cycles 3 and 7 after an accepted start → ignored, single done. start in the done cycle → accepted, second done 10 cycles later.
- rst_n low during SHIFT, with acc preloaded 0x33 and executing ADD → acc 0, flags 0, busy 0, no done pulse. A fresh LDI 0x01 then executes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, execution-unit FSM encoding and the
// default datapath width.
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_ADC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Opcodes 10..15 are undefined and execute as NOP.
  function automatic logic is_nop_class(input logic [3:0] op);
    return (op == OP_NOP) || (op > OP_SHR);
  endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice used LSB-first by the serial execution unit; the carry
// input/output doubles as the one-bit history needed by SHL.
module serial_alu_bit
  import cpu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_next,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       r,
  output logic       cout
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // through the block leaves it unassigned, which would infer a latch.
    r    = a;
    cout = cin;
    unique case (op)
      OP_LDI: r = b;
      OP_ADD, OP_SUB, OP_ADC: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin
        r    = cin;
        cout = a;
      end
      OP_SHR: r = a_next;
      default: ;
    endcase
  end

endmodule

// File: rtl/bit_serial_exec.sv
// Bit-serial execution unit: runs one instruction LSB-first through a 1-bit
// ALU over WIDTH cycles, holding the accumulator and the C/Z flags.
module bit_serial_exec
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [11:0]      instr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] acc_dbg,
  output logic             c_flag,
  output logic             z_flag
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic alu_r;
  logic alu_cout;

  serial_alu_bit u_alu (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .a_next (a_q[1]),
    .cin    (carry_q),
    .op     (op_q),
    .r      (alu_r),
    .cout   (alu_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = opcode;
          imm_d   = instr[WIDTH-1:0];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        a_d     = acc_q;
        // Subtraction is A + ~B + 1: invert B here, the +1 is the carry-in.
        b_d     = (op_q == OP_SUB) ? ~imm_q : imm_q;
        carry_d = (op_q == OP_SUB) ? 1'b1 : ((op_q == OP_ADC) ? c_q : 1'b0);
        res_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {alu_r, res_q[WIDTH-1:1]};
        carry_d = alu_cout;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (!is_nop_class(op_q)) begin
          acc_d = res_q;
          z_d   = (res_q == '0);
          unique case (op_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SHL: c_d = carry_q;
            // acc_q still holds the pre-shift value until this edge.
            OP_SHR:                         c_d = acc_q[0];
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  generate
    if (WIDTH < 12) begin : g_reserved
      logic unused_instr_hi;
      assign unused_instr_hi = ^instr[11:WIDTH];
    end
  endgenerate

  assign busy    = busy_q;
  assign done    = done_q;
  assign acc_out = acc_q;
  assign acc_dbg = a_q;
  assign c_flag  = c_q;
  assign z_flag  = z_q;

endmodule

// File: tb/tb_bit_serial_exec.sv
// Scoreboard bench for bit_serial_exec: directed sequences plus random
// instructions, checked against an arithmetic reference model.
module tb_bit_serial_exec;

  localparam int W    = 8;
  localparam int LAT  = W + 2;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [11:0]  instr;
  logic         busy;
  logic         done;
  logic [W-1:0] acc_out;
  logic [W-1:0] acc_dbg;
  logic         c_flag;
  logic         z_flag;

  bit_serial_exec #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .opcode  (opcode),
    .instr   (instr),
    .busy    (busy),
    .done    (done),
    .acc_out (acc_out),
    .acc_dbg (acc_dbg),
    .c_flag  (c_flag),
    .z_flag  (z_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] acc;
    logic         c;
    logic         z;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference architectural state
  int m_acc = 0;
  bit m_c   = 1'b0;
  bit m_z   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] op, input logic [7:0] imm);
    int a;
    int b;
    int s;
    a = m_acc;
    b = int'(imm) & MASK;
    case (op)
      4'd1: m_acc = b;
      4'd2: begin s = a + b;           m_c = ((s >> W) & 1) != 0; m_acc = s & MASK; end
      4'd3: begin m_c = (a >= b);      m_acc = (a - b) & MASK; end
      4'd4: m_acc = a & b;
      4'd5: m_acc = a | b;
      4'd6: m_acc = a ^ b;
      4'd7: begin s = a + b + int'(m_c); m_c = ((s >> W) & 1) != 0; m_acc = s & MASK; end
      4'd8: begin m_c = ((a >> (W - 1)) & 1) != 0; m_acc = (a << 1) & MASK; end
      4'd9: begin m_c = (a & 1) != 0;  m_acc = a >> 1; end
      default: ;
    endcase
    if (op >= 4'd1 && op <= 4'd9) m_z = (m_acc == 0);
  endtask

  // Raise start for one cycle; the next rising edge is the start edge E0.
  task automatic drive_start(input logic [3:0] op, input logic [7:0] imm, input bit expect_run);
    exp_t e;
    logic [3:0] junk;
    junk   = 4'($urandom);
    start  = 1'b1;
    opcode = op;
    instr  = {junk, imm};
    if (expect_run) begin
      model_step(op, imm);
      e.acc      = m_acc[W-1:0];
      e.c        = m_c;
      e.z        = m_z;
      e.done_cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_wait(output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] imm);
    int bc;
    drive_start(op, imm, 1'b1);
    run_wait(bc);
    check("busy_cycles", bc, LAT);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc_out",   acc_out, e.acc);
        check("c_flag",    c_flag,  e.c);
        check("z_flag",    z_flag,  e.z);
        check("busy_at_done", busy, 1'b0);
        check("done_cycle", cyc,   e.done_cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc;
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 4'd0;
    instr  = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    busy,    1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_acc",     acc_out, 8'h00);
    check("rst_acc_dbg", acc_dbg, 8'h00);
    check("rst_c",       c_flag,  1'b0);
    check("rst_z",       z_flag,  1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    exec(4'd1, 8'h5A);
    exec(4'd1, 8'hF0);
    exec(4'd2, 8'h20);
    exec(4'd3, 8'h10);
    exec(4'd3, 8'h01);
    exec(4'd1, 8'hFF);
    exec(4'd2, 8'h01);
    exec(4'd7, 8'h10);
    exec(4'd4, 8'h0F);
    exec(4'd5, 8'h80);
    exec(4'd6, 8'hFF);
    exec(4'd1, 8'h81);
    exec(4'd8, 8'h00);
    exec(4'd1, 8'h81);
    exec(4'd9, 8'h00);
    exec(4'hC, 8'h55);
    exec(4'd0, 8'hAA);

    // Starts at cycles 3 and 7 of an operation are ignored; a start in the
    // done cycle is accepted.
    drive_start(4'd1, 8'h3C, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; opcode = 4'd1; instr = 12'h099;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; opcode = 4'd6; instr = 12'h0FF;
    @(posedge clk); #1;
    start = 1'b0;
    run_wait(bc);
    drive_start(4'd2, 8'h11, 1'b1);
    run_wait(bc);
    check("b2b_busy_cycles", bc, LAT);
    repeat (15) @(posedge clk);
    #1;

    // Reset in the middle of an ADD leaves no trace of it.
    exec(4'd1, 8'hFF);
    exec(4'd2, 8'h01);
    exec(4'd1, 8'h33);
    drive_start(4'd2, 8'h44, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_acc",     acc_out, 8'h00);
    check("abort_acc_dbg", acc_dbg, 8'h00);
    check("abort_c",       c_flag,  1'b0);
    check("abort_z",       z_flag,  1'b0);
    check("abort_busy",    busy,    1'b0);
    check("abort_done",    done,    1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = 0;
    m_c   = 1'b0;
    m_z   = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    exec(4'd1, 8'h01);

    for (int i = 0; i < 60; i++) begin
      exec(4'($urandom_range(0, 15)), 8'($urandom));
    end

    repeat (5) @(posedge clk);
    check("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
